// File: rtl/fft_pad_serializer_if.sv
// Bundle of result-side and pad-side signals for the FFT output serializer.
// The slave modport is the serializer itself; the master modport is whatever
// feeds results in and watches the pads.
interface fft_pad_serializer_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 6,
  parameter int LANES  = 8,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              in_vld;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_dor;
  logic [DATA_W-1:0] in_doi;
  logic              out_en;
  logic              clr;
  logic [LANES-1:0]  pad_d;
  logic              pad_vld;
  logic              pad_frm;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              drop;

  modport master (
    output in_vld, in_addr, in_dor, in_doi, out_en, clr,
    input  pad_d, pad_vld, pad_frm, level, full, drop
  );

  modport slave (
    input  in_vld, in_addr, in_dor, in_doi, out_en, clr,
    output pad_d, pad_vld, pad_frm, level, full, drop
  );
endinterface

// File: rtl/fft_pad_serializer.sv
// Output serializer for the FFT core: buffers {addr, doi, dor} result words in
// a small circular FIFO and shifts each one out over LANES pads, LSB beat
// first, with a frame strobe on beat 0. The core cannot be stalled, so words
// arriving while the FIFO is full (and not draining) are dropped and flagged.
module fft_pad_serializer #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 6,
  parameter int LANES  = 8,
  parameter int DEPTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  fft_pad_serializer_if.slave bus
);
  localparam int W      = ADDR_W + 2 * DATA_W;
  localparam int BEATS  = (W + LANES - 1) / LANES;
  localparam int SR_W   = BEATS * LANES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              full_q;
  logic              drop_q;
  logic [BEAT_W-1:0] beat;
  logic [SR_W-1:0]   shreg;
  logic [LANES-1:0]  pad_d_q;
  logic              pad_vld_q;
  logic              pad_frm_q;

  logic [W-1:0]      in_word;
  logic [SR_W-1:0]   head_word;
  logic              pop;
  logic              push;
  logic              lose;
  logic [LVL_W-1:0]  level_next;

  // Pack the incoming word, zero-extend the head word to whole beats, and
  // decide push/pop/drop for this cycle. A pop frees a slot, so a full FIFO
  // still accepts a word in the same cycle it hands one to the shifter.
  always_comb begin
    in_word   = {bus.in_addr, bus.in_doi, bus.in_dor};
    head_word = '0;
    head_word[W-1:0] = mem[rd_ptr];
    pop  = bus.out_en && (level_q != '0) && ((state == IDLE) || (beat == BEAT_LAST));
    push = bus.in_vld && ((level_q != DEPTH_L) || pop);
    lose = bus.in_vld && !push;
    level_next = level_q;
    if (push && !pop) begin
      level_next = level_q + 1'b1;
    end else if (pop && !push) begin
      level_next = level_q - 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers and level do.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_word;
    end
  end

  // FIFO pointers, occupancy, full flag and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      level_q <= level_next;
      full_q  <= (level_next == DEPTH_L);
      if (lose) begin
        drop_q <= 1'b1;
      end else if (bus.clr) begin
        drop_q <= 1'b0;
      end
    end
  end

  // Shift FSM with registered pad outputs; everything freezes while out_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      shreg     <= '0;
      pad_d_q   <= '0;
      pad_vld_q <= 1'b0;
      pad_frm_q <= 1'b0;
    end else if (bus.out_en) begin
      if (pop) begin
        state     <= SHIFT;
        beat      <= '0;
        pad_d_q   <= head_word[LANES-1:0];
        shreg     <= head_word >> LANES;
        pad_vld_q <= 1'b1;
        pad_frm_q <= 1'b1;
      end else if (state == SHIFT) begin
        if (beat != BEAT_LAST) begin
          beat      <= beat + 1'b1;
          pad_d_q   <= shreg[LANES-1:0];
          shreg     <= shreg >> LANES;
          pad_frm_q <= 1'b0;
        end else begin
          state     <= IDLE;
          beat      <= '0;
          pad_d_q   <= '0;
          pad_vld_q <= 1'b0;
          pad_frm_q <= 1'b0;
        end
      end
    end
  end

  assign bus.pad_d   = pad_d_q;
  assign bus.pad_vld = pad_vld_q;
  assign bus.pad_frm = pad_frm_q;
  assign bus.level   = level_q;
  assign bus.full    = full_q;
  assign bus.drop    = drop_q;
endmodule

// File: tb/tb_fft_pad_serializer.sv
// Self-checking bench for fft_pad_serializer: a cycle model of the FIFO and
// shift sequencing pushes expected beats into a scoreboard when words are
// accepted, and a monitor pops and compares them as the pads advance.
module tb_fft_pad_serializer;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 6;
  localparam int LANES  = 8;
  localparam int DEPTH  = 4;
  localparam int W      = ADDR_W + 2 * DATA_W;
  localparam int BEATS  = (W + LANES - 1) / LANES;
  localparam int SR_W   = BEATS * LANES;

  typedef struct packed {
    logic [LANES-1:0] d;
    logic             frm;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_pad_serializer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  fft_pad_serializer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  beat_t            exp_q[$];
  logic [LANES-1:0] got_q[$];
  logic             got_frm_q[$];
  int               checks   = 0;
  int               failures = 0;

  int m_level = 0;
  bit m_idle  = 1'b1;
  int m_beat  = 0;
  bit m_drop  = 1'b0;
  bit m_pop;
  bit m_push;
  logic [SR_W-1:0] m_word;

  logic             mon_adv;
  logic             mon_rst;
  beat_t            mon_e;
  logic [LANES-1:0] prev_d   = '0;
  logic             prev_vld = 1'b0;
  logic             prev_frm = 1'b0;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of result-port input starting at a falling edge.
  task automatic apply_stimulus(input logic vld, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] doi, input logic [DATA_W-1:0] dor);
    bus.in_vld  = vld;
    bus.in_addr = addr;
    bus.in_doi  = doi;
    bus.in_dor  = dor;
    @(negedge clk);
    bus.in_vld  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, '0);
  endtask

  // Waits for the scoreboard to empty and the model to go idle, within a bound.
  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && m_idle) break;
      @(negedge clk);
    end
    check_output("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (got_q.size() >= n) break;
      @(negedge clk);
    end
    check_output("beats_reached", got_q.size() >= n, 1);
  endtask

  function automatic logic [LANES-1:0] beat_of(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] i,
                                               input logic [DATA_W-1:0] r, input int k);
    logic [SR_W-1:0] w;
    w = '0;
    w[W-1:0] = {a, i, r};
    return w[k*LANES +: LANES];
  endfunction

  // Reference model of occupancy and sequencing; accepted words enqueue their beats.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 0;
      m_idle  = 1'b1;
      m_beat  = 0;
      m_drop  = 1'b0;
      exp_q.delete();
    end else begin
      m_pop = bus.out_en && (m_level > 0) && (m_idle || m_beat == BEATS - 1);
      if (bus.out_en) begin
        if (m_pop) begin
          m_idle = 1'b0;
          m_beat = 0;
        end else if (!m_idle) begin
          if (m_beat == BEATS - 1) m_idle = 1'b1;
          else m_beat++;
        end
      end
      m_push = bus.in_vld && (m_level < DEPTH || m_pop);
      if (bus.in_vld && !m_push) m_drop = 1'b1;
      else if (bus.clr) m_drop = 1'b0;
      m_level = m_level + int'(m_push) - int'(m_pop);
      if (m_push) begin
        m_word = '0;
        m_word[W-1:0] = {bus.in_addr, bus.in_doi, bus.in_dor};
        for (int k = 0; k < BEATS; k++) exp_q.push_back('{d: m_word[k*LANES +: LANES], frm: (k == 0)});
      end
    end
  end

  // Pad monitor: compares each new beat against the scoreboard, holds while paused.
  always @(posedge clk) begin
    mon_adv = bus.out_en;
    mon_rst = rst;
    #1;
    if (!mon_rst && !rst) begin
      if (mon_adv) begin
        check_output("pad_vld", bus.pad_vld, !m_idle);
        if (bus.pad_vld) begin
          got_q.push_back(bus.pad_d);
          got_frm_q.push_back(bus.pad_frm);
          check_output("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_output("pad_d", bus.pad_d, mon_e.d);
            check_output("pad_frm", bus.pad_frm, mon_e.frm);
          end
        end else begin
          check_output("idle_pad_d", bus.pad_d, 0);
          check_output("idle_pad_frm", bus.pad_frm, 0);
        end
      end else begin
        check_output("hold_pad_d", bus.pad_d, prev_d);
        check_output("hold_pad_vld", bus.pad_vld, prev_vld);
        check_output("hold_pad_frm", bus.pad_frm, prev_frm);
      end
      check_output("level", bus.level, m_level);
      check_output("full", bus.full, m_level == DEPTH);
      check_output("drop", bus.drop, m_drop);
    end
    prev_d   = bus.pad_d;
    prev_vld = bus.pad_vld;
    prev_frm = bus.pad_frm;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    logic [LANES-1:0] vec1 [BEATS];
    logic [ADDR_W-1:0] la;
    logic [DATA_W-1:0] li, lr;
    vec1 = '{8'h45, 8'h23, 8'hF9, 8'hFF, 8'hBF, 8'h0A};

    bus.in_vld = 1'b0; bus.in_addr = '0; bus.in_doi = '0; bus.in_dor = '0;
    bus.out_en = 1'b1; bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_pad_d", bus.pad_d, 0);
    check_output("rst_pad_vld", bus.pad_vld, 0);
    check_output("rst_pad_frm", bus.pad_frm, 0);
    check_output("rst_level", bus.level, 0);
    check_output("rst_full", bus.full, 0);
    check_output("rst_drop", bus.drop, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single word, known vector.
    $display("[TB] single word");
    got_q.delete(); got_frm_q.delete();
    apply_stimulus(1'b1, 6'h2A, 19'h7FFFF, 19'h12345);
    check_output("latency_level", bus.level, 1);
    wait_drain(50);
    @(negedge clk);
    check_output("single_count", got_q.size(), BEATS);
    for (int k = 0; k < BEATS && k < got_q.size(); k++) begin
      check_output($sformatf("single_beat%0d", k), got_q[k], vec1[k]);
      check_output($sformatf("single_frm%0d", k), got_frm_q[k], k == 0);
    end
    check_output("single_vld_fall", bus.pad_vld, 0);

    // Two back-to-back words.
    $display("[TB] two words");
    got_q.delete(); got_frm_q.delete();
    apply_stimulus(1'b1, 6'h01, 19'h0AAAA, 19'h05555);
    apply_stimulus(1'b1, 6'h3E, 19'h1F0F0, 19'h70F0F);
    wait_drain(60);
    check_output("two_count", got_q.size(), 2 * BEATS);
    if (got_q.size() == 2 * BEATS) begin
      check_output("two_frm0", got_frm_q[0], 1);
      check_output("two_frm6", got_frm_q[BEATS], 1);
      check_output("two_last", got_q[2*BEATS-1], beat_of(6'h3E, 19'h1F0F0, 19'h70F0F, BEATS - 1));
    end

    // Pause for three cycles after beat 2.
    $display("[TB] pause mid-word");
    got_q.delete(); got_frm_q.delete();
    apply_stimulus(1'b1, 6'h2A, 19'h7FFFF, 19'h12345);
    wait_beats(3, 20);
    bus.out_en = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pause_held_d", bus.pad_d, vec1[2]);
    bus.out_en = 1'b1;
    wait_drain(50);
    check_output("pause_count", got_q.size(), BEATS);
    for (int k = 0; k < BEATS && k < got_q.size(); k++)
      check_output($sformatf("pause_beat%0d", k), got_q[k], vec1[k]);

    // Burst of six: the sixth word is lost.
    $display("[TB] overflow burst");
    got_q.delete(); got_frm_q.delete();
    for (int n = 0; n < 6; n++) begin
      la = ADDR_W'($urandom); li = DATA_W'($urandom); lr = DATA_W'($urandom);
      apply_stimulus(1'b1, la, li, lr);
    end
    check_output("burst_drop", bus.drop, 1);
    check_output("burst_full", bus.full, 1);
    wait_drain(100);
    check_output("burst_count", got_q.size(), 5 * BEATS);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check_output("clr_drop", bus.drop, 0);

    // Full FIFO: push coincides with the pop on the last beat.
    $display("[TB] full push with pop");
    got_q.delete(); got_frm_q.delete();
    for (int n = 0; n < 5; n++) apply_stimulus(1'b1, ADDR_W'(n + 1), DATA_W'(19'h100 * n), DATA_W'(n));
    idle_cycles(2);
    check_output("prefull_level", bus.level, DEPTH);
    apply_stimulus(1'b1, 6'h15, 19'h2BCDE, 19'h6789A);
    check_output("fullpop_level", bus.level, DEPTH);
    check_output("fullpop_drop", bus.drop, 0);
    wait_drain(100);
    check_output("fullpop_count", got_q.size(), 6 * BEATS);
    if (got_q.size() == 6 * BEATS)
      for (int k = 0; k < BEATS; k++)
        check_output($sformatf("fullpop_last%0d", k), got_q[5*BEATS+k], beat_of(6'h15, 19'h2BCDE, 19'h6789A, k));

    // Reset during beat 3 with two words queued.
    $display("[TB] reset mid-word");
    got_q.delete(); got_frm_q.delete();
    for (int n = 0; n < 3; n++) apply_stimulus(1'b1, ADDR_W'(n + 7), DATA_W'($urandom), DATA_W'($urandom));
    wait_beats(4, 20);
    #2 rst = 1'b1;
    #1;
    check_output("midrst_pad_d", bus.pad_d, 0);
    check_output("midrst_pad_vld", bus.pad_vld, 0);
    check_output("midrst_pad_frm", bus.pad_frm, 0);
    check_output("midrst_level", bus.level, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(20);
    check_output("postrst_silent", got_q.size(), 4);
    apply_stimulus(1'b1, 6'h2A, 19'h7FFFF, 19'h12345);
    wait_drain(50);
    check_output("postrst_count", got_q.size(), 4 + BEATS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_pad_serializer.md
# fft_pad_serializer

Parametrised output serializer that sits between the FFT core's result port and a reduced set of output pads. Each result word {ADDR, DOI, DOR} is buffered in a small FIFO and shifted out over `LANES` pads in `BEATS` consecutive beats, with a frame strobe and an external pause input. This removes the one-pad-per-bit limit on the output side, so wider data paths and larger transform sizes fit the same die perimeter.

## Interface
- `DATA_W`, default 19: width of each real and imaginary result component.
- `ADDR_W`, default 6: result address width (log2 of the transform size).
- `LANES`, default 8: number of output data pads.
- `DEPTH`, default 4: FIFO depth in words. Must be at least 2.
- Derived `W` = `ADDR_W` + 2·`DATA_W` (44 at defaults).
- Derived `BEATS` = ceil(`W`/`LANES`) (6 at defaults).
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `IN_VLD`  in  1  result word present this cycle (driven from core RDY/ED qualification).
- `IN_ADDR`  in  `ADDR_W`  result address.
- `IN_DOR`  in  `DATA_W`  result real part.
- `IN_DOI`  in  `DATA_W`  result imaginary part.
- `OUT_EN`  in  1  pad-side advance enable. When 0, the serializer holds its state and outputs.
- `CLR`  in  1  synchronous clear of `DROP`.
- `PAD_D`  out  `LANES`  current beat data.
- `PAD_VLD`  out  1  `PAD_D` carries a valid beat.
- `PAD_FRM`  out  1  high on beat 0 of each word.
- `LEVEL`  out  clog2(`DEPTH`+1)  FIFO occupancy.
- `FULL`  out  1  `LEVEL`==`DEPTH`.
- `DROP`  out  1  sticky flag: an input word was lost.

## Operation
- Word packing: word = {IN_ADDR, IN_DOI, IN_DOR}, with DOR at bits [DATA_W-1:0].
- Beat k carries word[k·LANES +: LANES], LSB beat first.
- Bits above `W` in the final beat are driven 0.
- FIFO is circular, with read and write pointers wrapping at `DEPTH`.
- Push is accepted when `IN_VLD`=1 and either `LEVEL`<`DEPTH` or a pop occurs in the same cycle.
- If `IN_VLD`=1, the FIFO is full and no pop occurs in that cycle, the word is discarded, `DROP` is set, and `LEVEL` is unchanged.
- `DROP` clears on `CLR`=1. If a set and a clear happen in the same cycle, set wins.
- The core cannot be back-pressured; `FULL` is informational only.
- State machine states: IDLE and SHIFT.
  - IDLE to SHIFT: `LEVEL`>0 and `OUT_EN`=1. Pop the head word into the shift register, drive beat 0, set `PAD_FRM`=1 and `PAD_VLD`=1, beat counter = 0.
  - SHIFT, `OUT_EN`=1, beat counter < `BEATS`-1: increment the counter, drive the next beat, `PAD_FRM`=0.
  - SHIFT, `OUT_EN`=1, beat counter = `BEATS`-1, `LEVEL`>0: pop and load the next word with no gap, `PAD_FRM`=1, stay in SHIFT.
  - SHIFT, `OUT_EN`=1, beat counter = `BEATS`-1, `LEVEL`=0: go to IDLE with `PAD_VLD`=0, `PAD_FRM`=0, `PAD_D`=0.
  - Any state, `OUT_EN`=0: state, counter, `PAD_*` and the FIFO read side all hold. The FIFO write side keeps accepting input.
- Simultaneous push and pop with `LEVEL`=`DEPTH`: both happen, `LEVEL` stays at `DEPTH`, no drop.
- Simultaneous push and pop with `LEVEL`=0 is impossible, since a pop requires `LEVEL`>0. The pushed word pops at the earliest the following cycle.

## Timing
- Reset values: `PAD_D`=0, `PAD_VLD`=0, `PAD_FRM`=0, `LEVEL`=0, `FULL`=0, `DROP`=0, state IDLE, pointers and counter 0.
- Reset asserted mid-word: the word in flight and the FIFO contents are discarded. No partial word is emitted after release.
- All outputs are registered.
- Latency: with IDLE, an empty FIFO and `OUT_EN`=1, a word pushed at edge N appears as beat 0 after edge N+1. `LEVEL` shows 1 after N and 0 after N+1.
- Sustained output rate is one word per `BEATS` cycles when `OUT_EN`=1. Input bursts longer than `DEPTH` + (burst cycles / `BEATS`) words drop.

## Test plan
- Defaults; push ADDR=6'h2A, DOI=19'h7FFFF, DOR=19'h12345 with `OUT_EN`=1 -> `PAD_D` sequence 45,23,F9,FF,BF,0A; `PAD_FRM` high only on 45; `PAD_VLD` falls after 0A.
- Push 2 words on consecutive cycles -> 12 contiguous valid beats; `PAD_FRM` on beats 0 and 6; no idle gap between the words.
- `OUT_EN`=0 held 3 cycles mid-word (after beat 2) -> beat 2 held for 4 cycles total, then beats 3–5 follow; data unchanged.
- Burst of 6 words on consecutive cycles -> words 1–5 are serialized intact, the 6th is dropped; `DROP`=1 from that edge on and `FULL` asserted; `CLR` pulse then clears `DROP`.
- `LEVEL`=`DEPTH` with a push coinciding with the last beat's pop -> no drop, `LEVEL` stays at `DEPTH`, and the new word is emitted last in order.
- Assert `RST` during beat 3 with 2 words queued -> all outputs 0 immediately; after release, nothing is emitted until a new push.
